// File: rtl/if_id_stage_reg.sv
// ============================================================================
// if_id_stage_reg
//
// IF/ID pipeline register sitting directly after the program counter. Each
// cycle it captures the fetched PC and instruction word and presents them to
// the decode stage together with a valid flag. Honours the global memory
// stall, the hazard unit's write enable and the branch flush with the same
// gating as the PC, and keeps saturating event counters for debug.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-low reset
//   start_i      CPU run enable; 0 loads bubbles
//   stall_i      global memory stall; 1 freezes all state, counters included
//   write_i      IF/ID write enable from the hazard unit; 0 holds the entry
//   flush_i      branch-taken flush; loads a bubble
//   pc_i         PC of the fetched instruction
//   instr_i      fetched instruction word (captured verbatim)
//   pc_o         registered PC to ID
//   instr_o      registered instruction to ID
//   valid_o      1 = instr_o is a real fetched instruction
//   fetch_cnt_o  real instructions loaded (saturating)
//   hold_cnt_o   hazard-hold cycles (saturating)
//   flush_cnt_o  flush cycles (saturating)
// ============================================================================
module if_id_stage_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             write_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      instr_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] hold_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [31:0]      pc_p1,    pc_nxt;
    logic [31:0]      instr_p1, instr_nxt;
    logic             vld_p1,   vld_nxt;
    logic [CNT_W-1:0] fetch_cnt, fetch_cnt_nxt;
    logic [CNT_W-1:0] hold_cnt,  hold_cnt_nxt;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_nxt;

    // Next-state selection; the if/else chain encodes the priority
    // stall > not-started > flush > hazard hold > normal load.
    always_comb begin
        pc_nxt        = pc_p1;
        instr_nxt     = instr_p1;
        vld_nxt       = vld_p1;
        fetch_cnt_nxt = fetch_cnt;
        hold_cnt_nxt  = hold_cnt;
        flush_cnt_nxt = flush_cnt;

        if (stall_i) begin
            // freeze everything; a pending flush is retried after the stall
        end else if (!start_i) begin
            pc_nxt    = '0;
            instr_nxt = NOP_INSTR;
            vld_nxt   = 1'b0;
        end else if (flush_i) begin
            // flush wins over a hazard hold so a branch squashes the held entry
            pc_nxt        = '0;
            instr_nxt     = NOP_INSTR;
            vld_nxt       = 1'b0;
            flush_cnt_nxt = sat_inc(flush_cnt);
        end else if (!write_i) begin
            hold_cnt_nxt = sat_inc(hold_cnt);
        end else begin
            pc_nxt        = pc_i;
            instr_nxt     = instr_i;
            vld_nxt       = 1'b1;
            fetch_cnt_nxt = sat_inc(fetch_cnt);
        end
    end

    // ---- IF -> ID stage boundary ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_p1     <= '0;
            instr_p1  <= NOP_INSTR;
            vld_p1    <= 1'b0;
            fetch_cnt <= '0;
            hold_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            pc_p1     <= pc_nxt;
            instr_p1  <= instr_nxt;
            vld_p1    <= vld_nxt;
            fetch_cnt <= fetch_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    assign pc_o        = pc_p1;
    assign instr_o     = instr_p1;
    assign valid_o     = vld_p1;
    assign fetch_cnt_o = fetch_cnt;
    assign hold_cnt_o  = hold_cnt;
    assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// ============================================================================
// tb_if_id_stage_reg
//
// Directed bench for if_id_stage_reg. A behavioural model pushes the expected
// register contents into a queue as each stimulus beat is driven; the entry is
// popped and compared after the following rising edge. A second instance with
// 4-bit counters exercises counter saturation on the same stimulus.
// ============================================================================
module tb_if_id_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, stall_i, write_i, flush_i;
    logic [31:0] pc_i, instr_i;

    logic [31:0] pc_o, instr_o;
    logic        valid_o;
    logic [15:0] fetch_cnt_o, hold_cnt_o, flush_cnt_o;

    logic [31:0] s_pc_o, s_instr_o;
    logic        s_valid_o;
    logic [3:0]  s_fetch_cnt_o, s_hold_cnt_o, s_flush_cnt_o;

    always #5 clk_i = ~clk_i;

    if_id_stage_reg #(.NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .write_i(write_i), .flush_i(flush_i), .pc_i(pc_i), .instr_i(instr_i),
        .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o),
        .fetch_cnt_o(fetch_cnt_o), .hold_cnt_o(hold_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    if_id_stage_reg #(.NOP_INSTR(NOP), .CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .write_i(write_i), .flush_i(flush_i), .pc_i(pc_i), .instr_i(instr_i),
        .pc_o(s_pc_o), .instr_o(s_instr_o), .valid_o(s_valid_o),
        .fetch_cnt_o(s_fetch_cnt_o), .hold_cnt_o(s_hold_cnt_o), .flush_cnt_o(s_flush_cnt_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        vld;
        logic [15:0] fc;
        logic [15:0] hc;
        logic [15:0] flc;
        logic [3:0]  fc4;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [31:0] m_pc, m_instr;
    logic        m_vld;
    logic [15:0] m_fc, m_hc, m_flc;
    logic [3:0]  m_fc4;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_instr = NOP; m_vld = 1'b0;
        m_fc = '0; m_hc = '0; m_flc = '0; m_fc4 = '0;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pc = m_pc; e.instr = m_instr; e.vld = m_vld;
        e.fc = m_fc; e.hc = m_hc; e.flc = m_flc; e.fc4 = m_fc4;
        return e;
    endfunction

    task automatic check_now(input string tag, input exp_t e);
        chk({tag, ".pc"},    pc_o,                  e.pc);
        chk({tag, ".instr"}, instr_o,               e.instr);
        chk({tag, ".valid"}, {31'd0, valid_o},      {31'd0, e.vld});
        chk({tag, ".fcnt"},  {16'd0, fetch_cnt_o},  {16'd0, e.fc});
        chk({tag, ".hcnt"},  {16'd0, hold_cnt_o},   {16'd0, e.hc});
        chk({tag, ".flcnt"}, {16'd0, flush_cnt_o},  {16'd0, e.flc});
        chk({tag, ".fcnt4"}, {28'd0, s_fetch_cnt_o}, {28'd0, e.fc4});
    endtask

    // Drive one beat, advance the model, push the expectation, clock, compare.
    task automatic step(input string tag, input logic st, input logic sl,
                        input logic wr, input logic fl,
                        input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        start_i = st; stall_i = sl; write_i = wr; flush_i = fl;
        pc_i = pc; instr_i = ins;
        if (sl) begin
        end else if (!st) begin
            m_pc = '0; m_instr = NOP; m_vld = 1'b0;
        end else if (fl) begin
            m_pc = '0; m_instr = NOP; m_vld = 1'b0;
            if (m_flc != 16'hFFFF) m_flc = m_flc + 16'd1;
        end else if (!wr) begin
            if (m_hc != 16'hFFFF) m_hc = m_hc + 16'd1;
        end else begin
            m_pc = pc; m_instr = ins; m_vld = 1'b1;
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            if (m_fc4 != 4'hF) m_fc4 = m_fc4 + 4'd1;
        end
        exp_q.push_back(snap());
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $error("FAIL %s: scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            check_now(tag, e);
        end
    endtask

    initial begin
        // reset held with live inputs: nothing may move
        rst_i = 1'b0; start_i = 1'b1; stall_i = 1'b0; write_i = 1'b1; flush_i = 1'b0;
        pc_i = 32'h0; instr_i = 32'h0050_0093;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_now("in_reset", snap());
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_now("post_release_pre_edge", snap());

        // first load
        step("load0",  1, 0, 1, 0, 32'h0000_0000, 32'h0050_0093);
        step("load4",  1, 0, 1, 0, 32'h0000_0004, 32'h0010_0113);
        step("load8",  1, 0, 1, 0, 32'h0000_0008, 32'h0020_8193);

        // hazard hold for three cycles while the PC moves on
        for (int i = 0; i < 3; i++)
            step("hold", 1, 0, 0, 0, 32'h0000_000C, 32'h0030_0213);
        chk("hold_total", {16'd0, hold_cnt_o}, 32'd3);
        step("hold_release", 1, 0, 1, 0, 32'h0000_000C, 32'h0030_0213);

        // flush beats a hazard hold
        step("flush_over_hold", 1, 0, 0, 1, 32'h0000_0010, 32'h0040_0293);

        // reload, then stall with flush asserted throughout
        step("load14", 1, 0, 1, 0, 32'h0000_0014, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++)
            step("stall_flush", 1, 1, 1, 1, 32'h0000_0018, 32'h0050_0313);
        step("flush_after_stall", 1, 0, 1, 1, 32'h0000_0018, 32'h0050_0313);

        // not started: bubble, counters unchanged
        step("load1c", 1, 0, 1, 0, 32'h0000_001C, 32'h1234_5678);
        step("no_start", 0, 0, 1, 0, 32'h0000_0020, 32'h0060_0393);

        // zero instruction is captured verbatim
        step("zero_instr", 1, 0, 1, 0, 32'h0000_0024, 32'h0000_0000);

        // async reset asserted mid-cycle during a hold
        step("load28", 1, 0, 1, 0, 32'h0000_0028, 32'hCAFE_F00D);
        step("hold2",  1, 0, 0, 0, 32'h0000_002C, 32'h0000_1111);
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        check_now("async_reset", snap());
        @(negedge clk_i);
        rst_i = 1'b1;

        // saturation: 4-bit instance pins at 15
        for (int i = 0; i < 20; i++)
            step("sat_load", 1, 0, 1, 0, 32'h0000_1000 + 32'(i) * 4, 32'h0000_0093 + 32'(i));
        chk("sat_fcnt4_final", {28'd0, s_fetch_cnt_o}, 32'd15);
        chk("sat_fcnt16_final", {16'd0, fetch_cnt_o}, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
